// File: rtl/accel_axi2apb_bridge_gen2.sv
// Request-beat to APB3/APB4 bridge. Each beat becomes one or two 32-bit APB transfers
// to a base/mask-decoded slave, with a per-transfer pready watchdog.
module accel_axi2apb_bridge_gen2 #(
    parameter int                        NSLV      = 4,
    parameter int                        ADDR_BITS = 48,
    parameter logic [NSLV*ADDR_BITS-1:0] SLV_BASE  = '0,
    parameter logic [NSLV*ADDR_BITS-1:0] SLV_MASK  = '0,
    parameter int                        TIMEOUT   = 255,
    parameter logic [2:0]                PPROT     = 3'b000
) (
    input  logic                   i_clk,
    input  logic                   i_nrst,
    input  logic                   i_req_valid,
    input  logic [ADDR_BITS-1:0]   i_req_addr,
    input  logic [7:0]             i_req_size,
    input  logic                   i_req_write,
    input  logic [63:0]            i_req_wdata,
    input  logic [7:0]             i_req_wstrb,
    input  logic                   i_req_last,
    output logic                   o_req_ready,
    output logic                   o_resp_valid,
    output logic [63:0]            o_resp_rdata,
    output logic                   o_resp_err,
    output logic [NSLV-1:0]        o_psel,
    output logic                   o_penable,
    output logic [31:0]            o_paddr,
    output logic                   o_pwrite,
    output logic [31:0]            o_pwdata,
    output logic [3:0]             o_pstrb,
    output logic [2:0]             o_pprot,
    input  logic [NSLV*32-1:0]     i_prdata,
    input  logic [NSLV-1:0]        i_pready,
    input  logic [NSLV-1:0]        i_pslverr,
    output logic                   o_timeout
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

    state_t          state;
    logic [NSLV-1:0] hit_sel;
    logic            hit;
    logic [7:0]      eff_size;
    logic            two_beat;
    logic            sel_ready;
    logic            sel_err;
    logic [31:0]     sel_rdata;
    logic            second_left;
    logic            single_beat;
    logic [31:0]     wdata_hi;
    logic [3:0]      wstrb_hi;
    logic [31:0]     to_cnt;
    logic            unused_last;

    // Burst position carries no meaning here: every beat is handled on its own.
    assign unused_last = i_req_last;

    // Handshake: a beat transfers on a cycle where i_req_valid && o_req_ready; ready is
    // high only in IDLE. The response is a one-cycle o_resp_valid pulse with no ready.
    assign o_req_ready = (state == IDLE);
    assign o_pprot     = PPROT;

    // Descending scan so the lowest-indexed matching slave is the one left selected.
    always_comb begin
        hit_sel = '0;
        hit     = 1'b0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if ((i_req_addr & SLV_MASK[i*ADDR_BITS +: ADDR_BITS]) == SLV_BASE[i*ADDR_BITS +: ADDR_BITS]) begin
                hit_sel    = '0;
                hit_sel[i] = 1'b1;
                hit        = 1'b1;
            end
        end
    end

    always_comb begin
        eff_size = (i_req_size == 8'd0 || i_req_size > 8'd8) ? 8'd8 : i_req_size;
        two_beat = (eff_size > 8'd4) && !i_req_addr[2];
    end

    // Only the slave currently selected may complete or fail the transfer.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (o_psel[i]) begin
                sel_ready = i_pready[i];
                sel_err   = i_pslverr[i];
                sel_rdata = i_prdata[i*32 +: 32];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state        <= IDLE;
            o_psel       <= '0;
            o_penable    <= 1'b0;
            o_paddr      <= '0;
            o_pwrite     <= 1'b0;
            o_pwdata     <= '0;
            o_pstrb      <= '0;
            o_resp_valid <= 1'b0;
            o_resp_rdata <= '0;
            o_resp_err   <= 1'b0;
            o_timeout    <= 1'b0;
            to_cnt       <= '0;
            second_left  <= 1'b0;
            single_beat  <= 1'b0;
            wdata_hi     <= '0;
            wstrb_hi     <= '0;
        end else begin
            o_resp_valid <= 1'b0;
            o_timeout    <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req_valid) begin
                        o_resp_err   <= 1'b0;
                        o_resp_rdata <= '0;
                        o_paddr      <= {i_req_addr[31:2], 2'b00};
                        o_pwrite     <= i_req_write;
                        wdata_hi     <= i_req_wdata[63:32];
                        wstrb_hi     <= i_req_wstrb[7:4];
                        second_left  <= two_beat;
                        single_beat  <= !two_beat;
                        if (i_req_addr[2]) begin
                            o_pwdata <= i_req_wdata[63:32];
                            o_pstrb  <= i_req_wstrb[7:4];
                        end else begin
                            o_pwdata <= i_req_wdata[31:0];
                            o_pstrb  <= i_req_wstrb[3:0];
                        end
                        if (hit) begin
                            o_psel <= hit_sel;
                            state  <= SETUP;
                        end else begin
                            o_resp_err   <= 1'b1;
                            o_resp_rdata <= '1;
                            o_resp_valid <= 1'b1;
                            state        <= RESP;
                        end
                    end
                end
                SETUP: begin
                    o_penable <= 1'b1;
                    to_cnt    <= '0;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    if (sel_ready) begin
                        if (single_beat) begin
                            o_resp_rdata <= {sel_rdata, sel_rdata};
                        end else if (o_paddr[2]) begin
                            o_resp_rdata[63:32] <= sel_rdata;
                        end else begin
                            o_resp_rdata[31:0] <= sel_rdata;
                        end
                        if (sel_err || !second_left) begin
                            o_resp_err   <= o_resp_err | sel_err;
                            second_left  <= 1'b0;
                            o_psel       <= '0;
                            o_penable    <= 1'b0;
                            o_resp_valid <= 1'b1;
                            state        <= RESP;
                        end else begin
                            second_left <= 1'b0;
                            o_paddr     <= o_paddr + 32'd4;
                            o_pwdata    <= wdata_hi;
                            o_pstrb     <= wstrb_hi;
                            o_penable   <= 1'b0;
                            state       <= SETUP;
                        end
                    end else begin
                        to_cnt <= to_cnt + 32'd1;
                        // The check uses the pre-increment count, so abort lands on ACCESS cycle TIMEOUT.
                        if ((TIMEOUT != 0) && (to_cnt == TO_LAST)) begin
                            o_psel       <= '0;
                            o_penable    <= 1'b0;
                            o_resp_err   <= 1'b1;
                            o_resp_rdata <= '1;
                            o_timeout    <= 1'b1;
                            o_resp_valid <= 1'b1;
                            state        <= RESP;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accel_axi2apb_bridge_gen2.sv
// Self-checking bench for accel_axi2apb_bridge_gen2: directed scenarios plus randomized
// requests, checked against a transaction-level model of decode, split, watchdog and errors.
module tb_accel_axi2apb_bridge_gen2;

    localparam int NSLV = 4;
    localparam int AB   = 48;
    localparam int TO   = 8;
    localparam logic [NSLV*AB-1:0] BASE = {48'h0000_C000_0000, 48'h0000_0000_0000,
                                           48'h0000_0000_1000, 48'h0000_0000_0000};
    localparam logic [NSLV*AB-1:0] MASK = {48'hFFFF_C000_0000, 48'hFFFF_FFFF_C000,
                                           48'hFFFF_FFFF_F000, 48'hFFFF_FFFF_F000};

    logic              clk;
    logic              nrst;
    logic              req_valid;
    logic              req_valid_nt;
    logic [AB-1:0]     req_addr;
    logic [7:0]        req_size;
    logic              req_write;
    logic [63:0]       req_wdata;
    logic [7:0]        req_wstrb;
    logic              req_last;
    logic [NSLV*32-1:0] prdata;
    logic [NSLV-1:0]   pready;
    logic [NSLV-1:0]   pready_nt;
    logic [NSLV-1:0]   pslverr;

    logic              req_ready, resp_valid, resp_err, penable, pwrite, to_pulse;
    logic [63:0]       resp_rdata;
    logic [NSLV-1:0]   psel;
    logic [31:0]       paddr, pwdata;
    logic [3:0]        pstrb;
    logic [2:0]        pprot;

    logic              nt_req_ready, nt_resp_valid, nt_resp_err, nt_penable, nt_pwrite, nt_timeout;
    logic [63:0]       nt_resp_rdata;
    logic [NSLV-1:0]   nt_psel;
    logic [31:0]       nt_paddr, nt_pwdata;
    logic [3:0]        nt_pstrb;
    logic [2:0]        nt_pprot;

    int n_checks = 0;
    int n_pass   = 0;
    logic [64:0] exp_q[$];
    logic [31:0] rd_q[$];

    accel_axi2apb_bridge_gen2 #(
        .NSLV(NSLV), .ADDR_BITS(AB), .SLV_BASE(BASE), .SLV_MASK(MASK),
        .TIMEOUT(TO), .PPROT(3'b010)
    ) dut (
        .i_clk(clk), .i_nrst(nrst),
        .i_req_valid(req_valid), .i_req_addr(req_addr), .i_req_size(req_size),
        .i_req_write(req_write), .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb),
        .i_req_last(req_last), .o_req_ready(req_ready),
        .o_resp_valid(resp_valid), .o_resp_rdata(resp_rdata), .o_resp_err(resp_err),
        .o_psel(psel), .o_penable(penable), .o_paddr(paddr), .o_pwrite(pwrite),
        .o_pwdata(pwdata), .o_pstrb(pstrb), .o_pprot(pprot),
        .i_prdata(prdata), .i_pready(pready), .i_pslverr(pslverr),
        .o_timeout(to_pulse)
    );

    accel_axi2apb_bridge_gen2 #(
        .NSLV(NSLV), .ADDR_BITS(AB), .SLV_BASE(BASE), .SLV_MASK(MASK),
        .TIMEOUT(0), .PPROT(3'b000)
    ) dut_nt (
        .i_clk(clk), .i_nrst(nrst),
        .i_req_valid(req_valid_nt), .i_req_addr(req_addr), .i_req_size(req_size),
        .i_req_write(req_write), .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb),
        .i_req_last(req_last), .o_req_ready(nt_req_ready),
        .o_resp_valid(nt_resp_valid), .o_resp_rdata(nt_resp_rdata), .o_resp_err(nt_resp_err),
        .o_psel(nt_psel), .o_penable(nt_penable), .o_paddr(nt_paddr), .o_pwrite(nt_pwrite),
        .o_pwdata(nt_pwdata), .o_pstrb(nt_pstrb), .o_pprot(nt_pprot),
        .i_prdata(prdata), .i_pready(pready_nt), .i_pslverr(pslverr),
        .o_timeout(nt_timeout)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode: the first slave whose masked address equals its base.
    function automatic int decode(input logic [AB-1:0] a);
        for (int i = 0; i < NSLV; i++)
            if ((a & MASK[i*AB +: AB]) == BASE[i*AB +: AB]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] slv_word(input int s, input logic [31:0] pa);
        return pa ^ {8'(s + 1), 24'h5AC396};
    endfunction

    // Drives one request, plays the APB slave with the given wait states / errors per beat,
    // and checks APB transfers and the response against the model.
    task automatic run_req(input logic [AB-1:0] addr, input logic [7:0] size, input logic wr,
                           input logic [63:0] wd, input logic [7:0] ws, input logic last,
                           input int w0, input int w1, input logic e0, input logic e1,
                           input string tag);
        int s, sz, nb, lat, nexec, n, acc, seen, viol, k;
        logic [31:0] pa[2];
        logic [31:0] pwd[2];
        logic [31:0] word[2];
        logic [3:0]  pst[2];
        int          wt[2];
        logic        er[2];
        logic        exp_err, exp_to, done, chk_rd;
        logic [63:0] exp_rd;
        logic [64:0] exp_e;
        logic [72:0] got_apb, exp_apb;

        wt[0] = w0; wt[1] = w1; er[0] = e0; er[1] = e1;
        s  = decode(addr);
        sz = (size == 8'd0 || size > 8'd8) ? 8 : int'(size);
        nb = (s < 0) ? 0 : ((sz > 4 && addr[2] == 1'b0) ? 2 : 1);
        for (int b = 0; b < 2; b++) begin
            pa[b]   = {addr[31:2], 2'b00} + 32'(4 * b);
            pwd[b]  = pa[b][2] ? wd[63:32] : wd[31:0];
            pst[b]  = pa[b][2] ? ws[7:4] : ws[3:0];
            word[b] = (b < nb && rd_q.size() > 0) ? rd_q.pop_front() : slv_word(s, pa[b]);
        end

        exp_err = (nb == 0);
        exp_to  = 1'b0;
        exp_rd  = (nb == 0) ? '1 : '0;
        lat     = 0;
        nexec   = 0;
        for (int b = 0; b < nb; b++) begin
            nexec++;
            if (wt[b] >= TO) begin
                exp_err = 1'b1; exp_to = 1'b1; exp_rd = '1;
                lat += 1 + TO;
                break;
            end
            lat += 2 + wt[b];
            if (nb == 1) exp_rd = {word[b], word[b]};
            else if (b == 0) exp_rd[31:0] = word[b];
            else exp_rd[63:32] = word[b];
            if (er[b]) begin
                exp_err = 1'b1;
                break;
            end
        end
        lat += 1;
        chk_rd = exp_to || (nb == 0) || (!wr && !exp_err);
        exp_q.push_back({exp_err, exp_rd});

        n_checks++;
        if (req_ready !== 1'b1) $display("FAIL %s idle_ready: got %b expected 1", tag, req_ready);
        else n_pass++;

        req_valid = 1'b1; req_addr = addr; req_size = size; req_write = wr;
        req_wdata = wd; req_wstrb = ws; req_last = last;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = {16'($urandom), 32'($urandom)};
        req_wdata = {$urandom, $urandom};
        req_wstrb = 8'($urandom);
        req_write = 1'($urandom);

        n = 1; acc = 0; seen = 0; viol = 0; done = 1'b0;
        while (!done && n < 300) begin
            if (resp_valid === 1'b1) begin
                exp_e = exp_q.pop_front();
                n_checks++;
                if (n != lat) $display("FAIL %s latency: got %0d expected %0d", tag, n, lat);
                else n_pass++;
                n_checks++;
                if (resp_err !== exp_e[64]) $display("FAIL %s resp_err: got %b expected %b", tag, resp_err, exp_e[64]);
                else n_pass++;
                if (chk_rd) begin
                    n_checks++;
                    if (resp_rdata !== exp_e[63:0]) $display("FAIL %s resp_rdata: got %h expected %h", tag, resp_rdata, exp_e[63:0]);
                    else n_pass++;
                end
                n_checks++;
                if (to_pulse !== exp_to) $display("FAIL %s timeout_pulse: got %b expected %b", tag, to_pulse, exp_to);
                else n_pass++;
                n_checks++;
                if (seen != nexec) $display("FAIL %s apb_transfers: got %0d expected %0d", tag, seen, nexec);
                else n_pass++;
                n_checks++;
                if (viol != 0) $display("FAIL %s protocol: got %0d violations expected 0", tag, viol);
                else n_pass++;
                done = 1'b1;
            end else begin
                if (to_pulse !== 1'b0 || req_ready !== 1'b0) viol++;
                pready  = 4'($urandom);
                pslverr = 4'($urandom);
                prdata  = {$urandom, $urandom, $urandom, $urandom};
                if (psel !== '0 && penable === 1'b0) begin
                    k = seen;
                    seen++;
                    acc = 0;
                    if (s < 0 || k > 1) viol++;
                    else begin
                        pready[s] = 1'b0;
                        got_apb = {psel, paddr, pwrite, pwdata, pstrb};
                        exp_apb = {4'(1 << s), pa[k], wr, pwd[k], pst[k]};
                        n_checks++;
                        if (got_apb !== exp_apb) $display("FAIL %s setup_beat%0d: got %h expected %h", tag, k, got_apb, exp_apb);
                        else n_pass++;
                    end
                end else if (psel !== '0 && penable === 1'b1) begin
                    k = seen - 1;
                    if (s < 0 || k < 0 || k > 1) viol++;
                    else begin
                        if ({psel, paddr, pwrite, pwdata, pstrb} !== {4'(1 << s), pa[k], wr, pwd[k], pst[k]}) viol++;
                        if (acc == wt[k]) begin
                            pready[s]  = 1'b1;
                            pslverr[s] = er[k];
                            prdata[s*32 +: 32] = word[k];
                        end else begin
                            pready[s] = 1'b0;
                        end
                    end
                    acc++;
                end else if (penable !== 1'b0) begin
                    viol++;
                end
            end
            @(negedge clk);
            n++;
        end
        pready = '0; pslverr = '0;
        if (!done) begin
            n_checks++;
            $display("FAIL %s no_response: got none after %0d cycles expected one at %0d", tag, n, lat);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
            n_checks++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b1)
                $display("FAIL %s post_idle: got valid=%b ready=%b expected valid=0 ready=1", tag, resp_valid, req_ready);
            else n_pass++;
        end
    endtask

    task automatic test_reset;
        nrst = 1'b0; req_valid = 1'b0; req_valid_nt = 1'b0; req_addr = '0; req_size = '0;
        req_write = 1'b0; req_wdata = '0; req_wstrb = '0; req_last = 1'b0;
        prdata = '0; pready = '0; pready_nt = '0; pslverr = '0;
        #12;
        n_checks++;
        if ({psel, penable, paddr, pwdata, pstrb, pwrite} !== '0)
            $display("FAIL reset_apb: got %h expected 0", {psel, penable, paddr, pwdata, pstrb, pwrite});
        else n_pass++;
        n_checks++;
        if ({resp_valid, resp_err, resp_rdata, to_pulse} !== '0)
            $display("FAIL reset_resp: got %h expected 0", {resp_valid, resp_err, resp_rdata, to_pulse});
        else n_pass++;
        n_checks++;
        if (pprot !== 3'b010) $display("FAIL pprot: got %b expected 010", pprot);
        else n_pass++;
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", req_ready);
        else n_pass++;
    endtask

    task automatic test_single_write;
        run_req(48'h1004, 8'd4, 1'b1, 64'hAABBCCDD_11223344, 8'hF0, 1'b1, 0, 0, 1'b0, 1'b0, "single_write");
    endtask

    task automatic test_split_read;
        rd_q.push_back(32'h11111111);
        rd_q.push_back(32'h22222222);
        run_req(48'h1000, 8'd8, 1'b0, 64'h0, 8'h00, 1'b1, 0, 0, 1'b0, 1'b0, "split_read");
        run_req(48'h2008, 8'd0, 1'b1, 64'h0123456789ABCDEF, 8'h3C, 1'b1, 1, 2, 1'b0, 1'b0, "split_write_size0");
        run_req(48'h200C, 8'd8, 1'b0, 64'h0, 8'h00, 1'b1, 0, 0, 1'b0, 1'b0, "upper_lane_size8");
    endtask

    task automatic test_unmapped;
        run_req(48'h9000, 8'd4, 1'b0, 64'h0, 8'h00, 1'b1, 0, 0, 1'b0, 1'b0, "unmapped");
        run_req(48'h0001_0000_1000, 8'd8, 1'b1, 64'h5, 8'hFF, 1'b1, 0, 0, 1'b0, 1'b0, "unmapped_upper");
    endtask

    task automatic test_overlap;
        run_req(48'h0040, 8'd4, 1'b0, 64'h0, 8'h00, 1'b1, 1, 0, 1'b0, 1'b0, "overlap_s0");
        run_req(48'h1044, 8'd2, 1'b0, 64'h0, 8'h00, 1'b1, 0, 0, 1'b0, 1'b0, "overlap_s1");
        run_req(48'hC000_0010, 8'd8, 1'b0, 64'h0, 8'h00, 1'b1, 2, 3, 1'b0, 1'b0, "slave3");
    endtask

    task automatic test_watchdog;
        run_req(48'h3000, 8'd4, 1'b0, 64'h0, 8'h00, 1'b1, 40, 0, 1'b0, 1'b0, "watchdog");
        run_req(48'h3010, 8'd8, 1'b0, 64'h0, 8'h00, 1'b1, 7, 40, 1'b0, 1'b0, "watchdog_beat2");
    endtask

    task automatic test_watchdog_off;
        int viol;
        viol = 0;
        req_addr = 48'h2000; req_size = 8'd4; req_write = 1'b0; req_valid_nt = 1'b1;
        prdata = '0; prdata[95:64] = 32'hC0FFEE01;
        @(negedge clk);
        req_valid_nt = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (nt_timeout !== 1'b0 || nt_resp_valid !== 1'b0 || nt_psel !== 4'b0100 || nt_penable !== 1'b1) viol++;
        end
        pready_nt = 4'b0100;
        @(negedge clk);
        pready_nt = '0;
        n_checks++;
        if (viol != 0) $display("FAIL wd_off_hold: got %0d violations expected 0", viol);
        else n_pass++;
        n_checks++;
        if ({nt_resp_valid, nt_resp_err} !== 2'b10)
            $display("FAIL wd_off_resp: got valid=%b err=%b expected valid=1 err=0", nt_resp_valid, nt_resp_err);
        else n_pass++;
        n_checks++;
        if (nt_resp_rdata !== 64'hC0FFEE01_C0FFEE01)
            $display("FAIL wd_off_rdata: got %h expected c0ffee01c0ffee01", nt_resp_rdata);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_abort;
        run_req(48'h1000, 8'd8, 1'b0, 64'h0, 8'h00, 1'b1, 1, 0, 1'b1, 1'b0, "abort_first");
        run_req(48'h1008, 8'd8, 1'b1, 64'hFACE, 8'hFF, 1'b1, 0, 2, 1'b0, 1'b1, "abort_second");
    endtask

    task automatic test_burst;
        for (int i = 0; i < 4; i++)
            run_req(48'h1000 + 48'(4 * i), 8'd4, 1'b0, 64'h0, 8'h00, (i == 3), i % 2, 0, 1'b0, 1'b0, "burst");
    endtask

    task automatic test_reset_mid;
        int viol;
        viol = 0;
        req_valid = 1'b1; req_addr = 48'h1000; req_size = 8'd4; req_write = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        pready = '0;
        n_checks++;
        if ({psel, penable} !== 5'b0010_1) $display("FAIL midrst_pre: got %b expected 00101", {psel, penable});
        else n_pass++;
        nrst = 1'b0;
        #1;
        n_checks++;
        if ({psel, penable} !== 5'b0) $display("FAIL midrst_drop: got %b expected 00000", {psel, penable});
        else n_pass++;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || psel !== '0) viol++;
        end
        nrst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || psel !== '0) viol++;
        end
        n_checks++;
        if (viol != 0) $display("FAIL midrst_quiet: got %0d violations expected 0", viol);
        else n_pass++;
        run_req(48'h1010, 8'd4, 1'b0, 64'h0, 8'h00, 1'b1, 0, 0, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_random;
        logic [AB-1:0] a;
        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 4))
                0, 1:    a = 48'($urandom_range(0, 32'h3FFF));
                2:       a = 48'h0000_C000_0000 + 48'($urandom_range(0, 32'h3FFF_FFFF));
                3:       a = 48'h9000 + 48'($urandom_range(0, 32'h6FFF));
                default: a = {16'h0001, 32'($urandom)};
            endcase
            run_req(a, 8'($urandom_range(0, 10)), 1'($urandom), {$urandom, $urandom}, 8'($urandom),
                    1'($urandom), ($urandom_range(0, 19) == 0) ? 12 : int'($urandom_range(0, 3)),
                    ($urandom_range(0, 19) == 0) ? 12 : int'($urandom_range(0, 3)),
                    ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0), "random");
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_split_read();
        test_unmapped();
        test_overlap();
        test_watchdog();
        test_watchdog_off();
        test_abort();
        test_burst();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
